crc_frame_rx: RTL

- Per-channel receive stage sitting directly upstream of the dual 48-bit comparator.
- Assembles a byte stream into frames of PAYLOAD_BYTES data bytes followed by 2 CRC-16 bytes, then checks the CRC.
- Presents the payload as one word with a one-cycle valid pulse; two instances feed the comparator's two data inputs.
- Frames failing CRC never reach the comparator; they raise crc_err instead.

---
 rtl/crc_frame_pkg.sv | 19 +
 rtl/crc_frame_rx_if.sv | 19 +
 rtl/crc16_byte.sv | 29 ++
 rtl/crc_frame_rx.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/crc_frame_pkg.sv
// crc_frame_pkg
//   Shared definitions for the CRC-16 framed byte receiver:
//   - state_t          : receiver FSM states (IDLE, PAYLOAD, CRC)
//   - CRC16_CCITT_POLY : default generator polynomial (MSB-first, non-reflected)
//   - CRC16_INIT       : default CRC seed at frame start
//   - CRC_BYTES        : number of CRC bytes trailing each payload
package crc_frame_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PAYLOAD = 2'd1,
        CRC     = 2'd2
    } state_t;

    localparam logic [15:0] CRC16_CCITT_POLY = 16'h1021;
    localparam logic [15:0] CRC16_INIT       = 16'hFFFF;
    localparam int          CRC_BYTES        = 2;

endpackage

// File: rtl/crc_frame_rx_if.sv
// crc_frame_rx_if
//   Received byte stream feeding one crc_frame_rx channel.
//   Signals:
//     byte_in    [7:0] : received byte
//     byte_valid       : byte_in valid this cycle
//     sof              : qualified by byte_valid; byte_in is payload byte 0
//   Modports:
//     master : byte source (drives the stream)
//     slave  : receiver (samples the stream)
interface crc_frame_rx_if;

    logic [7:0] byte_in;
    logic       byte_valid;
    logic       sof;

    modport master (output byte_in, output byte_valid, output sof);
    modport slave  (input  byte_in, input  byte_valid, input  sof);

endinterface

// File: rtl/crc16_byte.sv
// crc16_byte
//   Purely combinational byte-wise CRC-16 update, MSB-first, non-reflected.
//   Parameters:
//     POLY    : generator polynomial (implicit x^16 term)
//   Ports:
//     crc_in  [15:0] : CRC register before this byte
//     data_in [7:0]  : byte to fold in
//     crc_out [15:0] : CRC register after this byte
module crc16_byte #(
    parameter logic [15:0] POLY = 16'h1021
) (
    input  logic [15:0] crc_in,
    input  logic [7:0]  data_in,
    output logic [15:0] crc_out
);

    logic [15:0] c;

    always_comb begin
        // Folding the whole byte into the top bits first is equivalent to
        // shifting its bits in one at a time, MSB first.
        c = crc_in ^ {data_in, 8'h00};
        for (int i = 0; i < 8; i++) begin
            c = c[15] ? ((c << 1) ^ POLY) : (c << 1);
        end
        crc_out = c;
    end

endmodule

// File: rtl/crc_frame_rx.sv
// crc_frame_rx
//   Per-channel receive stage: assembles PAYLOAD_BYTES payload bytes plus two
//   CRC-16 bytes into a frame, checks the residue, and presents good payloads
//   as one word with a single-cycle valid pulse. Bad frames pulse crc_err.
//   Parameters:
//     PAYLOAD_BYTES : payload bytes per frame (data_out is PAYLOAD_BYTES*8 wide)
//     CRC_POLY      : CRC-16 polynomial
//     CRC_INIT      : CRC seed at frame start
//     TIMEOUT_CYC   : max idle clocks between bytes inside a frame
//   Optional feature macro: CRC_FRAME_RX_TIMEOUT_EN (inter-byte gap timeout).
//   Ports:
//     clk, rst    : clock (rising edge), synchronous active-high reset
//     rx          : byte stream (crc_frame_rx_if.slave)
//     data_out    : last CRC-good payload, byte 0 in the MSBs
//     data_valid  : one-cycle pulse, data_out just updated
//     crc_err     : one-cycle pulse, a frame completed with bad CRC
//     frame_abort : one-cycle pulse, a frame was abandoned
//     busy        : frame in progress
//     err_cnt     : saturating count of crc_err events
module crc_frame_rx
    import crc_frame_pkg::*;
#(
    parameter int          PAYLOAD_BYTES = 6,
    parameter logic [15:0] CRC_POLY      = CRC16_CCITT_POLY,
    parameter logic [15:0] CRC_INIT      = CRC16_INIT,
    parameter int          TIMEOUT_CYC   = 255
) (
    input  logic                       clk,
    input  logic                       rst,
    crc_frame_rx_if.slave              rx,
    output logic [PAYLOAD_BYTES*8-1:0] data_out,
    output logic                       data_valid,
    output logic                       crc_err,
    output logic                       frame_abort,
    output logic                       busy,
    output logic [7:0]                 err_cnt
);

    localparam int DW = PAYLOAD_BYTES * 8;
    localparam int CW = $clog2(PAYLOAD_BYTES + 1);

    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("crc_frame_rx: TIMEOUT_CYC must be at least 1");
    end

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [15:0]   crc, crc_seed, crc_upd;
    logic [DW-1:0] shreg;
    logic          start, accept, abort, done, chk_p, timeout;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign busy   = (state != IDLE);
    assign start  = rx.byte_valid && rx.sof;
    assign accept = rx.byte_valid && (busy || rx.sof);

    // A start-of-frame byte always seeds from CRC_INIT, whatever the register holds.
    assign crc_seed = start ? CRC_INIT : crc;

    crc16_byte #(.POLY(CRC_POLY)) u_crc (
        .crc_in  (crc_seed),
        .data_in (rx.byte_in),
        .crc_out (crc_upd)
    );

`ifdef CRC_FRAME_RX_TIMEOUT_EN
    localparam int GW = $clog2(TIMEOUT_CYC + 1);
    logic [GW-1:0] gap;

    assign timeout = busy && !rx.byte_valid && (gap == GW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst || !busy || rx.byte_valid || timeout) gap <= '0;
        else                                          gap <= gap + 1'b1;
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        abort     = 1'b0;
        done      = 1'b0;
        if (start) begin
            // sof restarts the frame from any state; only a live frame counts as aborted.
            abort = busy;
            if (PAYLOAD_BYTES == 1) begin
                state_nxt = CRC;
                cnt_nxt   = '0;
            end else begin
                state_nxt = PAYLOAD;
                cnt_nxt   = CW'(1);
            end
        end else if (rx.byte_valid) begin
            case (state)
                PAYLOAD: begin
                    if (cnt == CW'(PAYLOAD_BYTES - 1)) begin
                        state_nxt = CRC;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                CRC: begin
                    if (cnt == CW'(CRC_BYTES - 1)) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                        done      = 1'b1;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end else if (timeout) begin
            abort     = 1'b1;
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            crc         <= CRC_INIT;
            chk_p       <= 1'b0;
            data_valid  <= 1'b0;
            crc_err     <= 1'b0;
            frame_abort <= 1'b0;
            err_cnt     <= 8'd0;
            data_out    <= '0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            if (accept) crc <= crc_upd;
            chk_p       <= done;
            frame_abort <= abort;
            // Result stage: the residue of the just-finished frame is still in
            // crc and its payload in shreg, even if a new sof is accepted now.
            data_valid  <= chk_p && (crc == 16'h0000);
            crc_err     <= chk_p && (crc != 16'h0000);
            if (chk_p && (crc == 16'h0000)) data_out <= shreg;
            if (chk_p && (crc != 16'h0000)) err_cnt  <= sat_inc(err_cnt);
        end
    end

    // Payload shift register: only payload bytes shift in, CRC bytes do not.
    always_ff @(posedge clk) begin
        if (accept && (start || state == PAYLOAD)) shreg <= DW'({shreg, rx.byte_in});
    end

endmodule
